// File: rtl/sap_ram_loader.sv
// Programming front-end for the 16x8 SAP-1 RAM: streams bytes into RAM over the shared bus,
// reads every written location back and compares byte checksums.
module sap_ram_loader #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    inout  wire  [7:0]        DATA,
    output logic              ram_address_enable,
    output logic              ram_write_enable,
    output logic              ram_output_enable,
    output logic              cpu_halt,
    output logic              busy,
    output logic              done,
    output logic              verify_ok,
    output logic              verify_err,
    output logic [ADDR_W:0]   byte_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_BYTE, S_WR_ADDR, S_WR_DATA,
        S_RB_ADDR, S_RB_READ, S_CHECK, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, rb_addr;
    logic [ADDR_W:0]   count;
    logic [7:0]        wsum, rsum;
    logic [7:0]        byte_reg;
    logic              last_reg;
    logic              bus_drive;
    logic [7:0]        bus_out;
    logic              wr_end, rb_end;

    function automatic logic [7:0] addr_word(input logic [ADDR_W-1:0] a);
        logic [7:0] w;
        w = '0;
        w[ADDR_W-1:0] = a;
        return w;
    endfunction

    // The top address ends the write phase even without in_last, so RAM can never overflow.
    assign wr_end = last_reg || (addr == ADDR_W'(DEPTH - 1));
    assign rb_end = ({1'b0, rb_addr} == (count - 1'b1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt          = state;
        in_ready           = 1'b0;
        ram_address_enable = 1'b0;
        ram_write_enable   = 1'b0;
        ram_output_enable  = 1'b0;
        bus_drive          = 1'b0;
        bus_out            = '0;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_WAIT_BYTE;
            S_WAIT_BYTE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_WR_ADDR;
            end
            S_WR_ADDR: begin
                bus_drive          = 1'b1;
                bus_out            = addr_word(addr);
                ram_address_enable = 1'b1;
                state_nxt          = S_WR_DATA;
            end
            S_WR_DATA: begin
                bus_drive        = 1'b1;
                bus_out          = byte_reg;
                ram_write_enable = 1'b1;
                state_nxt        = wr_end ? S_RB_ADDR : S_WAIT_BYTE;
            end
            S_RB_ADDR: begin
                bus_drive          = 1'b1;
                bus_out            = addr_word(rb_addr);
                ram_address_enable = 1'b1;
                state_nxt          = S_RB_READ;
            end
            S_RB_READ: begin
                ram_output_enable = 1'b1;
                state_nxt         = rb_end ? S_CHECK : S_RB_ADDR;
            end
            S_CHECK: state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= '0;
            rb_addr    <= '0;
            count      <= '0;
            wsum       <= '0;
            rsum       <= '0;
            last_reg   <= 1'b0;
            verify_ok  <= 1'b0;
            verify_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) begin
                    addr       <= '0;
                    rb_addr    <= '0;
                    count      <= '0;
                    wsum       <= '0;
                    rsum       <= '0;
                    last_reg   <= 1'b0;
                    verify_ok  <= 1'b0;
                    verify_err <= 1'b0;
                end
                S_WAIT_BYTE: if (in_valid) begin
                    last_reg <= in_last;
                    wsum     <= wsum + in_data;
                    count    <= count + 1'b1;
                end
                S_WR_DATA: begin
                    if (wr_end) rb_addr <= '0;
                    else        addr    <= addr + 1'b1;
                end
                S_RB_READ: begin
                    rsum <= rsum + DATA;
                    if (!rb_end) rb_addr <= rb_addr + 1'b1;
                end
                S_CHECK: begin
                    verify_ok  <= (rsum == wsum);
                    verify_err <= (rsum != wsum);
                end
                default: ;
            endcase
        end
    end

    // Captured byte is pure data and needs no reset.
    always_ff @(posedge clk) begin
        if (state == S_WAIT_BYTE && in_valid) byte_reg <= in_data;
    end

    assign DATA       = bus_drive ? bus_out : 8'bzzzz_zzzz;
    assign busy       = (state != S_IDLE) && (state != S_DONE);
    assign cpu_halt   = busy;
    assign done       = (state == S_DONE);
    assign byte_count = count;

endmodule

// File: tb/tb_sap_ram_loader.sv
// Bench for sap_ram_loader: behavioural 16x8 RAM on the shared bus, write scoreboard,
// table of program loads plus hand-written reset and restart sequences.
module tb_sap_ram_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       in_ready;
    wire  [7:0] DATA;
    logic       ram_address_enable, ram_write_enable, ram_output_enable;
    logic       cpu_halt, busy, done, verify_ok, verify_err;
    logic [4:0] byte_count;

    sap_ram_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready), .DATA(DATA),
        .ram_address_enable(ram_address_enable), .ram_write_enable(ram_write_enable),
        .ram_output_enable(ram_output_enable), .cpu_halt(cpu_halt), .busy(busy),
        .done(done), .verify_ok(verify_ok), .verify_err(verify_err),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    // RAM model; optional corruption of address 5 on readback only
    logic [7:0] mem [16];
    logic [3:0] ram_addr = '0;
    bit         flip_en = 1'b0;
    logic [7:0] rd_word;
    assign rd_word = mem[ram_addr] ^ ((flip_en && ram_addr == 4'd5) ? 8'h01 : 8'h00);
    assign DATA = ram_output_enable ? rd_word : 8'bzzzz_zzzz;
    always @(posedge clk) begin
        if (ram_address_enable) ram_addr <= DATA[3:0];
        if (ram_write_enable)   mem[ram_addr] <= DATA;
    end

    typedef struct { int addr; logic [7:0] data; } wr_t;
    typedef struct {
        int n; int kind; int gap; bit use_last; bit flip; bit mid_start; bit exp_ok; int exp_time;
    } vec_t;

    wr_t        q[$];
    wr_t        mon_e;
    int         total = 0;
    int         bad = 0;
    int         writes = 0;
    int         reads = 0;
    bit         abort = 1'b0;
    logic [7:0] prog [16];
    logic [7:0] k1 [3];
    vec_t       vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("enable_onehot",
                32'(ram_address_enable) + 32'(ram_write_enable) + 32'(ram_output_enable) <= 1, 1);
            if (ram_output_enable) begin
                reads++;
                chk("bus_no_contention", 32'($isunknown(DATA)), 0);
            end
            if (in_ready) begin
                chk("wait_enables_low", {ram_address_enable, ram_write_enable, ram_output_enable}, 0);
                chk("wait_bus_z", 32'(DATA === 8'bzzzz_zzzz), 1);
            end
            if (ram_write_enable) begin
                writes++;
                if (q.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    mon_e = q.pop_front();
                    chk("write_addr", 32'(ram_addr), mon_e.addr);
                    chk("write_data", DATA, mon_e.data);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic l, input int idx);
        int t = 0;
        in_valid = 1'b1; in_data = b; in_last = l;
        while (!abort) begin
            if (in_ready) begin
                q.push_back('{idx, b});
                @(negedge clk);
                return;
            end
            @(negedge clk);
            t++;
            if (t > 300) begin
                chk("in_ready_timeout", 0, 1);
                abort = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic make_prog(input vec_t v);
        for (int i = 0; i < 16; i++) begin
            case (v.kind)
                0:       prog[i] = 8'(i);
                1:       prog[i] = (i < 3) ? k1[i] : 8'h00;
                default: prog[i] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic run_load(input vec_t v);
        int cyc = 0;
        make_prog(v);
        q.delete(); writes = 0; reads = 0; flip_en = v.flip; abort = 1'b0;
        pulse_start();
        chk("start_clears_done", done, 0);
        chk("start_clears_ok", verify_ok, 0);
        chk("start_clears_err", verify_err, 0);
        chk("start_clears_count", byte_count, 0);
        chk("busy_after_start", {busy, cpu_halt}, 2'b11);
        fork
            begin
                for (int i = 0; i < v.n; i++) begin
                    if (abort) break;
                    if (v.gap > 0) begin
                        int g = $urandom_range(0, v.gap);
                        in_valid = 1'b0;
                        repeat (g) @(negedge clk);
                    end
                    send_byte(prog[i], v.use_last && (i == v.n - 1), i);
                end
                in_valid = 1'b0; in_last = 1'b0;
            end
            begin
                while (!done && cyc < 3000) begin
                    @(posedge clk); cyc++;
                    @(negedge clk);
                end
            end
            begin
                if (v.mid_start) begin
                    repeat (10) @(negedge clk);
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
        join
        chk("done_seen", done, 1);
        if (v.exp_time != 0) chk("done_latency", cyc, v.exp_time);
        chk("verify_ok", verify_ok, v.exp_ok);
        chk("verify_err", verify_err, !v.exp_ok);
        chk("byte_count", byte_count, v.n);
        chk("idle_after_done", {busy, cpu_halt}, 0);
        chk("write_cycles", writes, v.n);
        chk("read_cycles", reads, v.n);
        chk("scoreboard_empty", q.size(), 0);
        for (int i = 0; i < v.n; i++) chk("ram_image", mem[i], prog[i]);
    endtask

    initial begin
        k1[0] = 8'hA5; k1[1] = 8'h5A; k1[2] = 8'hFF;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        //          n  kind gap last flip mid ok time
        vecs[0] = '{16, 0, 0, 0, 0, 0, 1, 81};
        vecs[1] = '{ 3, 1, 0, 1, 0, 0, 1, 16};
        vecs[2] = '{16, 0, 5, 0, 0, 0, 1, 0};
        vecs[3] = '{16, 2, 0, 0, 1, 0, 0, 81};
        vecs[4] = '{ 9, 2, 3, 1, 0, 0, 1, 0};
        vecs[5] = '{ 4, 2, 0, 1, 1, 0, 1, 21};
        vecs[6] = '{16, 0, 0, 0, 0, 1, 1, 81};
        vecs[7] = '{ 1, 2, 0, 1, 0, 0, 1, 6};

        #1;
        chk("reset_outputs",
            {in_ready, ram_address_enable, ram_write_enable, ram_output_enable,
             cpu_halt, busy, done, verify_ok, verify_err}, 0);
        chk("reset_count", byte_count, 0);
        chk("reset_bus_z", 32'(DATA === 8'bzzzz_zzzz), 1);
        @(negedge clk); rst_n = 1'b1;

        for (int k = 0; k < 8; k++) run_load(vecs[k]);

        // Reset during the write cycle of byte 7, then a clean reload
        make_prog(vecs[0]);
        q.delete(); flip_en = 1'b0; abort = 1'b0;
        pulse_start();
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    if (abort) break;
                    send_byte(prog[i], 1'b0, i);
                end
                in_valid = 1'b0;
            end
            begin
                int t = 0;
                while (!(ram_write_enable && ram_addr == 4'd7) && t < 500) begin
                    @(negedge clk); t++;
                end
                chk("reached_byte7_write", 32'(ram_write_enable && ram_addr == 4'd7), 1);
                #2 rst_n = 1'b0; abort = 1'b1;
                #1;
                chk("async_reset_outputs",
                    {in_ready, ram_address_enable, ram_write_enable, ram_output_enable,
                     cpu_halt, busy, done, verify_ok, verify_err}, 0);
                chk("async_reset_count", byte_count, 0);
                chk("async_reset_bus_z", 32'(DATA === 8'bzzzz_zzzz), 1);
            end
        join
        @(negedge clk); rst_n = 1'b1; abort = 1'b0; q.delete();
        run_load(vecs[2]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
